// File: rtl/decodificador_secded_param_if.sv
// decodificador_secded_param_if: codeword input channel and decoded result channel
// Input channel : entrada_valida/entrada_lista handshake, palabra, inyectar, mascara_error
// Output channel: salida_valida/salida_lista handshake, dato_corregido, sindrome, error_simple, error_doble
// slave = decoder side, master = producer/consumer side
interface decodificador_secded_param_if #(
    parameter int DATA_W = 4
);
    function automatic int calc_p(input int dw);
        int p;
        p = 0;
        for (int i = 1; i < 8; i++) if (p == 0 && (1 << i) >= dw + i + 1) p = i;
        return p;
    endfunction
    localparam int P = calc_p(DATA_W);
    localparam int N = DATA_W + P + 1;
    logic              entrada_valida;
    logic              entrada_lista;
    logic [N-1:0]      palabra;
    logic              inyectar;
    logic [N-1:0]      mascara_error;
    logic              salida_valida;
    logic              salida_lista;
    logic [DATA_W-1:0] dato_corregido;
    logic [P-1:0]      sindrome;
    logic              error_simple;
    logic              error_doble;
    modport slave (
        input  entrada_valida, palabra, inyectar, mascara_error, salida_lista,
        output entrada_lista, salida_valida, dato_corregido, sindrome, error_simple, error_doble
    );
    modport master (
        output entrada_valida, palabra, inyectar, mascara_error, salida_lista,
        input  entrada_lista, salida_valida, dato_corregido, sindrome, error_simple, error_doble
    );
endinterface

// File: rtl/decodificador_secded_param.sv
// decodificador_secded_param: two-stage extended-Hamming SECDED decoder with saturating error counters
// reloj, reinicio_n      : clock, synchronous active-low reset
// bus (slave modport)    : codeword in with injection mask, decoded data/syndrome/flags out
// limpiar_contadores     : synchronous clear of both counters (wins over an increment)
// cuenta_simple/doble    : saturating counts of single/double errors seen at output handshakes
module decodificador_secded_param #(
    parameter int DATA_W   = 4,
    parameter bit CORREGIR = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic                        reloj,
    input  logic                        reinicio_n,
    decodificador_secded_param_if.slave bus,
    input  logic                        limpiar_contadores,
    output logic [CNT_W-1:0]            cuenta_simple,
    output logic [CNT_W-1:0]            cuenta_doble
);
    function automatic int calc_p(input int dw);
        int p;
        p = 0;
        for (int i = 1; i < 8; i++) if (p == 0 && (1 << i) >= dw + i + 1) p = i;
        return p;
    endfunction
    // codeword bit index holding data bit k: k-th non-power-of-two Hamming position, minus one
    function automatic int data_bit(input int k);
        int c, r;
        c = 0;
        r = 0;
        for (int i = 0; i < 64; i++) begin
            if (((i + 1) & i) != 0) begin
                if (c == k) r = i;
                c++;
            end
        end
        return r;
    endfunction
    localparam int P = calc_p(DATA_W);
    localparam int N = DATA_W + P + 1;
    logic              s1_valid_q, s1_valid_d;
    logic [N-1:0]      r_q, r_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] dato_q, dato_d;
    logic [P-1:0]      sind_q, sind_d;
    logic              es_q, es_d;
    logic              ed_q, ed_d;
    logic [CNT_W-1:0]  cs_q, cs_d;
    logic [CNT_W-1:0]  cd_q, cd_d;
    logic              s2_load, in_hs, out_hs, ld;
    logic [P-1:0]      syn;
    logic              st, in_rng, fix;
    logic [DATA_W-1:0] dato_x;
    assign s2_load = !s2_valid_q || bus.salida_lista;
    assign in_hs   = bus.entrada_valida && bus.entrada_lista;
    assign out_hs  = s2_valid_q && bus.salida_lista;
    assign ld      = s2_load && s1_valid_q;
    always_comb begin
        syn = '0;
        for (int i = 0; i < N - 1; i++) syn = syn ^ (r_q[i] ? P'(i + 1) : '0);
        st = ^r_q;
        // shortened codes leave syndromes beyond the last position unmapped
        in_rng = 32'(syn) < N;
        fix = CORREGIR && st && in_rng;
    end
    // correction folded into extraction: only a data bit whose position equals the syndrome flips
    for (genvar k = 0; k < DATA_W; k++) begin : g_dato
        localparam int B = data_bit(k);
        assign dato_x[k] = r_q[B] ^ (fix && syn == P'(B + 1));
    end
    always_comb begin
        s1_valid_d = in_hs || (s1_valid_q && !s2_load);
        r_d        = in_hs ? bus.palabra ^ (bus.inyectar ? bus.mascara_error : '0) : r_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        dato_d     = ld ? dato_x : dato_q;
        sind_d     = ld ? syn : sind_q;
        es_d       = ld ? st && in_rng : es_q;
        ed_d       = ld ? syn != '0 && (!st || !in_rng) : ed_q;
        cs_d       = limpiar_contadores ? '0 : (out_hs && es_q && cs_q != '1) ? cs_q + CNT_W'(1) : cs_q;
        cd_d       = limpiar_contadores ? '0 : (out_hs && ed_q && cd_q != '1) ? cd_q + CNT_W'(1) : cd_q;
    end
    always_ff @(posedge reloj) begin
        if (!reinicio_n) begin
            s1_valid_q <= 1'b0;
            r_q        <= '0;
            s2_valid_q <= 1'b0;
            dato_q     <= '0;
            sind_q     <= '0;
            es_q       <= 1'b0;
            ed_q       <= 1'b0;
            cs_q       <= '0;
            cd_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            r_q        <= r_d;
            s2_valid_q <= s2_valid_d;
            dato_q     <= dato_d;
            sind_q     <= sind_d;
            es_q       <= es_d;
            ed_q       <= ed_d;
            cs_q       <= cs_d;
            cd_q       <= cd_d;
        end
    end
    assign bus.entrada_lista  = !s1_valid_q || s2_load;
    assign bus.salida_valida  = s2_valid_q;
    assign bus.dato_corregido = dato_q;
    assign bus.sindrome       = sind_q;
    assign bus.error_simple   = es_q;
    assign bus.error_doble    = ed_q;
    assign cuenta_simple      = cs_q;
    assign cuenta_doble       = cd_q;
endmodule

// File: tb/tb_decodificador_secded_param.sv
// tb_decodificador_secded_param: directed scoreboard bench, correcting (CNT_W=8) and detect-only (CNT_W=2) decoders side by side
module tb_decodificador_secded_param;
    typedef struct {
        logic [3:0] d;
        logic [2:0] s;
        logic       se;
        logic       de;
    } exp_t;
    logic       clk, rst_n, ev, inj, sl, lim;
    logic [7:0] pal, msk;
    logic [7:0] csa, cda;
    logic [1:0] csb, cdb;
    int         checks, failures;
    exp_t       qa[$], qb[$];
    exp_t       ea, eb;
    decodificador_secded_param_if #(.DATA_W(4)) ifa ();
    decodificador_secded_param_if #(.DATA_W(4)) ifb ();
    assign ifa.entrada_valida = ev;
    assign ifa.palabra        = pal;
    assign ifa.inyectar       = inj;
    assign ifa.mascara_error  = msk;
    assign ifa.salida_lista   = sl;
    assign ifb.entrada_valida = ev;
    assign ifb.palabra        = pal;
    assign ifb.inyectar       = inj;
    assign ifb.mascara_error  = msk;
    assign ifb.salida_lista   = sl;
    decodificador_secded_param #(.DATA_W(4), .CORREGIR(1'b1), .CNT_W(8)) dut_a (
        .reloj(clk), .reinicio_n(rst_n), .bus(ifa), .limpiar_contadores(lim),
        .cuenta_simple(csa), .cuenta_doble(cda)
    );
    decodificador_secded_param #(.DATA_W(4), .CORREGIR(1'b0), .CNT_W(2)) dut_b (
        .reloj(clk), .reinicio_n(rst_n), .bus(ifb), .limpiar_contadores(lim),
        .cuenta_simple(csb), .cuenta_doble(cdb)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction
    always @(negedge clk) begin
        if (rst_n && ifa.salida_valida && ifa.salida_lista) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected: got output %0h with empty queue", ifa.dato_corregido);
            end else begin
                ea = qa.pop_front();
                chk("a_dato", 32'(ifa.dato_corregido), 32'(ea.d));
                chk("a_sindrome", 32'(ifa.sindrome), 32'(ea.s));
                chk("a_error_simple", 32'(ifa.error_simple), 32'(ea.se));
                chk("a_error_doble", 32'(ifa.error_doble), 32'(ea.de));
            end
        end
        if (rst_n && ifb.salida_valida && ifb.salida_lista) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected: got output %0h with empty queue", ifb.dato_corregido);
            end else begin
                eb = qb.pop_front();
                chk("b_dato", 32'(ifb.dato_corregido), 32'(eb.d));
                chk("b_sindrome", 32'(ifb.sindrome), 32'(eb.s));
                chk("b_error_simple", 32'(ifb.error_simple), 32'(eb.se));
                chk("b_error_doble", 32'(ifb.error_doble), 32'(eb.de));
            end
        end
    end
    // call just after a rising edge; returns just after the edge that accepted the word
    task automatic send(input logic [7:0] w, input logic i, input logic [7:0] m, input logic [3:0] da,
                        input logic [3:0] db, input logic [2:0] s, input logic se, input logic de);
        int n;
        n = 0;
        ev = 1'b1;
        pal = w;
        inj = i;
        msk = m;
        @(negedge clk);
        while (!(ifa.entrada_lista && ifb.entrada_lista) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(ifa.entrada_lista && ifb.entrada_lista)) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got entrada_lista %b/%b required 1", ifa.entrada_lista, ifb.entrada_lista);
        end else begin
            qa.push_back('{da, s, se, de});
            qb.push_back('{db, s, se, de});
        end
        @(posedge clk);
        #1;
        ev = 1'b0;
        inj = 1'b0;
        msk = '0;
    endtask
    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(qa.size() + qb.size()), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask
    logic [3:0] snap_d;
    logic [2:0] snap_s;
    int         w;
    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        ev = 1'b0;
        inj = 1'b0;
        pal = '0;
        msk = '0;
        sl = 1'b1;
        lim = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a_valid", 32'(ifa.salida_valida), 0);
        chk("rst_a_lista", 32'(ifa.entrada_lista), 1);
        chk("rst_a_cnt", 32'({csa, cda}), 0);
        chk("rst_b_valid", 32'(ifb.salida_valida), 0);
        chk("rst_b_cnt", 32'({csb, cdb}), 0);
        @(posedge clk);
        #1;
        send(8'h55, 1'b0, 8'h00, 4'hB, 4'hB, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("latency_not_yet", 32'(ifa.salida_valida), 0);
        @(negedge clk);
        chk("latency_two", 32'(ifa.salida_valida), 1);
        drain();
        send(8'h55, 1'b1, 8'h10, 4'hB, 4'h9, 3'd5, 1'b1, 1'b0);
        drain();
        chk("a_cnt_s_1", 32'(csa), 1);
        chk("b_cnt_s_1", 32'(csb), 1);
        send(8'hD5, 1'b0, 8'h00, 4'hB, 4'hB, 3'd0, 1'b1, 1'b0);
        send(8'h45, 1'b0, 8'h00, 4'hB, 4'h9, 3'd5, 1'b1, 1'b0);
        send(8'h56, 1'b0, 8'h00, 4'hB, 4'hB, 3'd3, 1'b0, 1'b1);
        drain();
        chk("a_cnt_s_3", 32'(csa), 3);
        chk("b_cnt_s_3", 32'(csb), 3);
        chk("a_cnt_d_1", 32'(cda), 1);
        chk("b_cnt_d_1", 32'(cdb), 1);
        send(8'h45, 1'b0, 8'h00, 4'hB, 4'h9, 3'd5, 1'b1, 1'b0);
        send(8'hD5, 1'b0, 8'h00, 4'hB, 4'hB, 3'd0, 1'b1, 1'b0);
        drain();
        chk("a_cnt_s_5", 32'(csa), 5);
        chk("b_cnt_s_sat", 32'(csb), 3);
        sl = 1'b0;
        send(8'h55, 1'b0, 8'h00, 4'hB, 4'hB, 3'd0, 1'b0, 1'b0);
        send(8'h45, 1'b0, 8'h00, 4'hB, 4'h9, 3'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_a_lista_low", 32'(ifa.entrada_lista), 0);
        chk("bp_b_lista_low", 32'(ifb.entrada_lista), 0);
        chk("bp_a_valid", 32'(ifa.salida_valida), 1);
        snap_d = ifa.dato_corregido;
        snap_s = ifa.sindrome;
        chk("bp_held_dato", 32'(snap_d), 32'hB);
        repeat (2) begin
            @(negedge clk);
            chk("bp_stable_dato", 32'(ifa.dato_corregido), 32'(snap_d));
            chk("bp_stable_sindrome", 32'(ifa.sindrome), 32'(snap_s));
            chk("bp_stable_lista", 32'(ifa.entrada_lista), 0);
        end
        @(posedge clk);
        #1;
        sl = 1'b1;
        send(8'h56, 1'b0, 8'h00, 4'hB, 4'hB, 3'd3, 1'b0, 1'b1);
        drain();
        chk("a_cnt_s_6", 32'(csa), 6);
        chk("a_cnt_d_2", 32'(cda), 2);
        chk("b_cnt_d_2", 32'(cdb), 2);
        send(8'h45, 1'b0, 8'h00, 4'hB, 4'h9, 3'd5, 1'b1, 1'b0);
        w = 0;
        @(negedge clk);
        while (!ifa.salida_valida && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("clr_wait_valid", 32'(ifa.salida_valida), 1);
        lim = 1'b1;
        @(posedge clk);
        #1;
        lim = 1'b0;
        @(negedge clk);
        chk("clr_a_cnt", 32'({csa, cda}), 0);
        chk("clr_b_cnt", 32'({csb, cdb}), 0);
        drain();
        send(8'h45, 1'b0, 8'h00, 4'hB, 4'h9, 3'd5, 1'b1, 1'b0);
        drain();
        chk("a_cnt_s_after_clr", 32'(csa), 1);
        sl = 1'b0;
        send(8'h55, 1'b0, 8'h00, 4'hB, 4'hB, 3'd0, 1'b0, 1'b0);
        send(8'h56, 1'b0, 8'h00, 4'hB, 4'hB, 3'd3, 1'b0, 1'b1);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_a_valid", 32'(ifa.salida_valida), 0);
        chk("mrst_a_outs", 32'({ifa.dato_corregido, ifa.sindrome, ifa.error_simple, ifa.error_doble}), 0);
        chk("mrst_a_lista", 32'(ifa.entrada_lista), 1);
        chk("mrst_a_cnt", 32'({csa, cda}), 0);
        chk("mrst_b_valid", 32'(ifb.salida_valida), 0);
        chk("mrst_b_cnt", 32'({csb, cdb}), 0);
        sl = 1'b1;
        @(posedge clk);
        #1;
        send(8'h55, 1'b0, 8'h00, 4'hB, 4'hB, 3'd0, 1'b0, 1'b0);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end
endmodule

// File: doc/decodificador_secded_param.md
Name: decodificador_secded_param

Overview:
- Parametrised, pipelined extended-Hamming SECDED decoder.
- Accepts one codeword per cycle over a valid/ready handshake and applies an optional error-injection mask.
- Computes syndrome and overall parity, corrects single-bit errors, and flags double-bit errors.
- Sits between the encoder/channel model and the display/consumer logic; keeps saturating error-event counters for the board status readout.

Parameters:
- DATA_W, 4: data bits per word; legal values 1..57.
- P, derived (not overridable): smallest integer with 2^P >= DATA_W+P+1; DATA_W=4 gives P=3.
- N, derived: codeword width, DATA_W+P+1; DATA_W=4 gives N=8.
- CORREGIR, 1: 1 = correct single errors; 0 = detect only, data passes through raw.
- CNT_W, 8: width of each error counter.

Ports:
- reloj  in  1  clock; all state updates on the rising edge.
- reinicio_n  in  1  reset, synchronous, active-low.
- entrada_valida  in  1  codeword present.
- entrada_lista  out  1  decoder can accept a codeword.
- palabra  in  N  received codeword.
- inyectar  in  1  when 1, mascara_error is XORed into palabra at capture.
- mascara_error  in  N  error-injection mask.
- salida_valida  out  1  result present.
- salida_lista  in  1  consumer accepts the result.
- dato_corregido  out  DATA_W  decoded data.
- sindrome  out  P  Hamming syndrome (1-based error position, 0 = none).
- error_simple  out  1  correctable single error.
- error_doble  out  1  uncorrectable error.
- limpiar_contadores  in  1  synchronous clear of both counters.
- cuenta_simple  out  CNT_W  saturating count of single errors.
- cuenta_doble  out  CNT_W  saturating count of double errors.

Behaviour:
- Bit mapping:
  - Codeword bit i (i < N-1) holds Hamming position i+1.
  - Power-of-two positions are parity bits; remaining positions hold data in ascending order (data bit 0 at position 3).
  - Bit N-1 is overall even parity.
  - For DATA_W=4: data sits at bits 2,4,5,6, matching the existing decoder layout.
- Syndrome and parity:
  - sindrome[k] = XOR of all bits i < N-1 whose position (i+1) has bit k set.
  - st = XOR of all N bits.
- Stage 1: on an input handshake (entrada_valida & entrada_lista), register r = palabra ^ (inyectar ? mascara_error : 0) and set stage-1 valid.
- Stage 2: compute sindrome and st from r, classify, correct, and register all outputs with salida_valida.
- Latency: 2 cycles from input handshake to salida_valida. Throughput: 1 word/cycle.
- Classification:
  - sindrome==0, st==0: no error.
  - sindrome!=0, st==1, sindrome <= N-1: error_simple. If CORREGIR=1, flip bit sindrome-1 before data extraction.
  - sindrome==0, st==1: error_simple (overall parity bit only); data unchanged.
  - sindrome!=0, st==0: error_doble; data extracted uncorrected.
  - sindrome > N-1 (shortened codes): error_doble.
  - error_simple and error_doble are never both 1.
- Handshake:
  - Stage 2 loads when it is empty or salida_lista=1.
  - Stage 1 advances when stage 2 loads.
  - entrada_lista = !stage1_valid | stage2 loads (combinational, no dependence on entrada_valida).
  - While salida_valida=1 and salida_lista=0, all outputs hold stable.
- Counters:
  - Increment on an output handshake (salida_valida & salida_lista) with the respective flag set.
  - Saturate at 2^CNT_W-1.
  - limpiar_contadores has priority over a same-cycle increment; the result is 0.
- Reset (reinicio_n=0 at an edge):
  - Both valids cleared; dato_corregido, sindrome, error_simple, error_doble, and both counters go to 0.
  - entrada_lista reads 1 in the cycle after reset.
  - In-flight words are discarded; reset mid-stall drops the held result.
- Outputs are registered, except entrada_lista.

Test Plan (DATA_W=4, N=8 unless stated; clean code for data 4'hB is 8'h55):
- Clean word: palabra=8'h55, inyectar=0, salida_lista=1 -> 2 cycles later salida_valida=1, dato_corregido=4'hB, sindrome=0, both flags 0.
- Single error via injection: palabra=8'h55, inyectar=1, mascara_error=8'h10 -> sindrome=3'b101, error_simple=1, dato_corregido=4'hB, cuenta_simple=1.
- Overall parity bit and detect-only mode:
  - 8'hD5 -> sindrome=0, error_simple=1, dato=4'hB.
  - With CORREGIR=0, 8'h45 -> error_simple=1, dato_corregido=4'h9.
- Double error: 8'h56 -> sindrome=3'b011, error_doble=1, error_simple=0, dato_corregido=4'hB uncorrected, cuenta_doble=1.
- Backpressure:
  - Stream 8'h55, 8'h45, 8'h56 back-to-back with salida_lista=0 for 3 cycles -> entrada_lista drops after two words buffered, outputs stable.
  - On release, the three results emerge in order with no loss or duplication.
- Counters and reset:
  - With CNT_W=2, 5 single-error words -> cuenta_simple=3 (saturated).
  - limpiar_contadores together with an error handshake -> 0.
  - reinicio_n=0 with both stages full -> next cycle salida_valida=0, all outputs 0, entrada_lista=1.
